// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, reset PC default,
// PC step and the target alignment helper.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_KILL = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Next fetch PC: a redirect beats a sequential step, and execute beats decode.
// Purely combinational, no latency and no flow control of its own.
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] fetch_pc,
    input  logic        id_jump_flag,
    input  logic [31:0] id_jump_pc,
    input  logic        ex_btype_taken,
    input  logic [31:0] ex_btype_jump_pc,
    input  logic        redirect_en,
    input  logic        advance,
    output logic        redirect,
    output logic [31:0] next_pc
);

    logic [31:0] target;

    always_comb begin
        redirect = ex_btype_taken | id_jump_flag;
        target   = ex_btype_taken ? ex_btype_jump_pc : id_jump_pc;
        next_pc  = fetch_pc;
        if (redirect && redirect_en) begin
            next_pc = word_align(target);
        end else if (advance) begin
            // Wraps modulo 2^32 by construction.
            next_pc = fetch_pc + PC_INC;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one Icache request outstanding, redirects kill in-flight responses.
// Response visible one cycle after acceptance at best; fc_bk_if_i only withholds new requests.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fc_bk_if_i,
    input  logic        id_jump_flag_i,
    input  logic [31:0] id_jump_pc_i,
    input  logic        ex_btype_taken_i,
    input  logic [31:0] ex_btype_jump_pc_i,
    output logic        if_Icache_req_o,
    output logic [31:0] if_Icache_addr_o,
    input  logic        Icache_ready_i,
    input  logic        Icache_data_valid_i,
    output logic [31:0] if_pc_o,
    output logic        if_inst_valid_o
);

    if_state_e   state;
    if_state_e   state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic        redirect;
    logic        redirect_en;
    logic        advance;

    pc_next_sel u_pc_next_sel (
        .fetch_pc         (fetch_pc),
        .id_jump_flag     (id_jump_flag_i),
        .id_jump_pc       (id_jump_pc_i),
        .ex_btype_taken   (ex_btype_taken_i),
        .ex_btype_jump_pc (ex_btype_jump_pc_i),
        .redirect_en      (redirect_en),
        .advance          (advance),
        .redirect         (redirect),
        .next_pc          (fetch_pc_nxt)
    );

    always_comb begin
        state_nxt       = state;
        if_Icache_req_o = 1'b0;
        if_inst_valid_o = 1'b0;
        redirect_en     = 1'b0;
        advance         = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                redirect_en     = 1'b1;
                if_Icache_req_o = !redirect && !fc_bk_if_i;
                if (if_Icache_req_o && Icache_ready_i) begin
                    advance   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                redirect_en     = 1'b1;
                if_inst_valid_o = Icache_data_valid_i && !redirect;
                if (Icache_data_valid_i) begin
                    state_nxt = ST_REQ;
                end else if (redirect) begin
                    state_nxt = ST_KILL;
                end
            end
            ST_KILL: begin
                // Response belongs to the abandoned path; swallow it.
                redirect_en = 1'b1;
                if (Icache_data_valid_i) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            if_pc_o  <= 32'h0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (advance) begin
                if_pc_o <= fetch_pc;
            end
        end
    end

    assign if_Icache_addr_o = fetch_pc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table followed by a randomised Icache scoreboard run.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fc = 1'b0;
    logic        jf = 1'b0;
    logic [31:0] jpc = 32'h0;
    logic        bt = 1'b0;
    logic [31:0] bpc = 32'h0;
    logic        rdy = 1'b0;
    logic        dv = 1'b0;

    logic        req,  req2;
    logic [31:0] addr, addr2;
    logic [31:0] pc,   pc2;
    logic        vld,  vld2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk                (clk),
        .rst                (rst),
        .fc_bk_if_i         (fc),
        .id_jump_flag_i     (jf),
        .id_jump_pc_i       (jpc),
        .ex_btype_taken_i   (bt),
        .ex_btype_jump_pc_i (bpc),
        .if_Icache_req_o    (req),
        .if_Icache_addr_o   (addr),
        .Icache_ready_i     (rdy),
        .Icache_data_valid_i(dv),
        .if_pc_o            (pc),
        .if_inst_valid_o    (vld)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk                (clk),
        .rst                (rst),
        .fc_bk_if_i         (fc),
        .id_jump_flag_i     (jf),
        .id_jump_pc_i       (jpc),
        .ex_btype_taken_i   (bt),
        .ex_btype_jump_pc_i (bpc),
        .if_Icache_req_o    (req2),
        .if_Icache_addr_o   (addr2),
        .Icache_ready_i     (rdy),
        .Icache_data_valid_i(dv),
        .if_pc_o            (pc2),
        .if_inst_valid_o    (vld2)
    );

    typedef struct {
        logic        rst, fc, jf;
        logic [31:0] jpc;
        logic        bt;
        logic [31:0] bpc;
        logic        rdy, dv;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic        a2chk;
        logic [31:0] ea2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic f, input logic j, input logic [31:0] jp,
        input logic b, input logic [31:0] bp, input logic rd, input logic d,
        input logic eq, input logic [31:0] ea, input logic ev, input logic [31:0] ep,
        input logic a2c, input logic [31:0] a2);
        vec_t v;
        v.rst = r; v.fc = f; v.jf = j; v.jpc = jp; v.bt = b; v.bpc = bp;
        v.rdy = rd; v.dv = d; v.ereq = eq; v.eaddr = ea; v.evld = ev; v.epc = ep;
        v.a2chk = a2c; v.ea2 = a2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    logic [31:0] sbq[$];
    logic [31:0] mpc;
    logic [31:0] exp_pc;
    bit          outst;

    initial begin
        //            rst fc jf jpc         bt bpc         rdy dv  req addr        vld pc          a2c a2
        tbl.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h0,   0, 32'h0,   1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 1,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h0,   0, 32'h0,   1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h4,   1, 32'h0,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h4,   0, 32'h0,   1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h8,   1, 32'h4,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h8,   0, 32'h4,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'hC,   1, 32'h8,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'hC,   0, 32'h8,   0, 32'h0));
        // Decode jump while waiting: response will be killed, target realigned.
        tbl.push_back(mk(0, 0, 1, 32'h103, 0, 32'h0,   1, 0,   0, 32'h10,  0, 32'hC,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h100, 0, 32'hC,   0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h300, 1, 32'h200, 1, 0,   0, 32'h100, 0, 32'hC,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h200, 0, 32'hC,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h204, 1, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 0,   0, 32'h204, 0, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 0,   0, 32'h204, 0, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 0,   0, 32'h204, 0, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h204, 0, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h208, 1, 32'h204, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0,   1, 32'h208, 0, 32'h204, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h208, 0, 32'h204, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h400, 0, 32'h0,   0, 1,   0, 32'h20C, 0, 32'h208, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h400, 0, 32'h208, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h503, 0, 0,   0, 32'h404, 0, 32'h400, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h600, 0, 32'h0,   0, 0,   0, 32'h500, 0, 32'h400, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h600, 0, 32'h400, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0,   1, 32'h600, 0, 32'h400, 0, 32'h0));
        // Reset lands in WAIT together with a response.
        tbl.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 1,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 1,   0, 32'h0,   0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0,   1, 32'h0,   0, 32'h0,   0, 32'h0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; fc = tbl[i].fc; jf = tbl[i].jf; jpc = tbl[i].jpc;
            bt = tbl[i].bt; bpc = tbl[i].bpc; rdy = tbl[i].rdy; dv = tbl[i].dv;
            @(negedge clk);
            check($sformatf("row%0d req", i),  {31'b0, req}, {31'b0, tbl[i].ereq});
            check($sformatf("row%0d addr", i), addr, tbl[i].eaddr);
            check($sformatf("row%0d vld", i),  {31'b0, vld}, {31'b0, tbl[i].evld});
            check($sformatf("row%0d pc", i),   pc, tbl[i].epc);
            if (tbl[i].a2chk) begin
                check($sformatf("row%0d wrap_addr", i), addr2, tbl[i].ea2);
            end
            @(posedge clk);
            #1;
        end

        // Random Icache timing and flow-control stalls, no redirects.
        mpc   = 32'h0;
        outst = 1'b0;
        jf = 1'b0; bt = 1'b0; rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            fc  = ($urandom_range(0, 3) == 0);
            rdy = $urandom_range(0, 1) == 1;
            dv  = outst && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check("sb req", {31'b0, req}, {31'b0, (!outst && !fc)});
            if (!outst && !fc) begin
                check("sb addr", addr, mpc);
            end
            check("sb vld", {31'b0, vld}, {31'b0, dv});
            if (dv) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb empty: got response want none");
                end else begin
                    exp_pc = sbq.pop_front();
                    check("sb pc", pc, exp_pc);
                end
                outst = 1'b0;
            end else if (!outst && !fc && rdy) begin
                sbq.push_back(mpc);
                mpc   = mpc + 32'd4;
                outst = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
